cpu_sequencer: RTL

//  Multi-cycle control FSM for the 18-bit processor. It sequences PC, instruction ROM, RegFile, ALU, data RAM and comparator.

---
 rtl/cpu_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the 18-bit processor.
// Walks FETCH/DECODE/EXEC/MEM/WB for each instruction. It latches the fetched word into an
// internal IR, holds the comparator flags used by the conditional jumps, and drives every
// datapath strobe.
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             run request; a rising edge starts from IDLE or HALT
//   instr             ROM word at the current PC
//   cmp_result        comparator {gt,eq,lt}
//   dp_reset          one-cycle clear pulse to PC and RegFile
//   pc_inc, pc_wrt    PC increment / PC load strobes; pc_target is the load value
//   r1_addr, r2_addr  RegFile read addresses; w_addr and regw_enable form the write port
//   alu_select        one-hot ALU op; alu_b_imm selects imm_ext as the ALU b operand
//   imm_ext           sign-extended imm6
//   wb_sel            write-back source (0 ALU, 1 RAM)
//   ram_addr          data RAM address; ram_w_enable is the RAM write strobe
//   busy, halted      status
module cpu_sequencer #(
    parameter int unsigned DATA_W = 18,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RA_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] instr,
    input  logic [2:0]        cmp_result,
    output logic              dp_reset,
    output logic              pc_inc,
    output logic              pc_wrt,
    output logic [ADDR_W-1:0] pc_target,
    output logic [RA_W-1:0]   r1_addr,
    output logic [RA_W-1:0]   r2_addr,
    output logic [RA_W-1:0]   w_addr,
    output logic              regw_enable,
    output logic [3:0]        alu_select,
    output logic              alu_b_imm,
    output logic [DATA_W-1:0] imm_ext,
    output logic              wb_sel,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_enable,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [2:0] {
        StIdle, StRst, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpAnd  = 4'h1;
    localparam logic [3:0] OpNand = 4'h2;
    localparam logic [3:0] OpNor  = 4'h3;
    localparam logic [3:0] OpAddi = 4'h4;
    localparam logic [3:0] OpAndi = 4'h5;
    localparam logic [3:0] OpLd   = 4'h6;
    localparam logic [3:0] OpSt   = 4'h7;
    localparam logic [3:0] OpCmp  = 4'h8;
    localparam logic [3:0] OpJmp  = 4'h9;
    localparam logic [3:0] OpJe   = 4'hA;
    localparam logic [3:0] OpJa   = 4'hB;
    localparam logic [3:0] OpJb   = 4'hC;
    localparam logic [3:0] OpJae  = 4'hD;
    localparam logic [3:0] OpJbe  = 4'hE;
    localparam logic [3:0] OpIll  = 4'hF;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [2:0]        flags_q, flags_d;  // {gt,eq,lt}
    logic              start_q;

    logic [3:0]      op;
    logic [RA_W-1:0] rd, rs1, rs2;
    logic            is_alu, is_mem, is_jump, jump_taken, start_rise;

    assign op  = ir_q[17:14];
    assign rd  = ir_q[13:10];
    assign rs1 = ir_q[9:6];
    assign rs2 = ir_q[3:0];

    assign is_alu     = (op <= OpAndi);
    assign is_mem     = (op == OpLd) || (op == OpSt);
    assign is_jump    = (op >= OpJmp) && (op <= OpJbe);
    assign start_rise = start && !start_q;

    always_comb begin
        jump_taken = 1'b0;
        case (op)
            OpJmp:   jump_taken = 1'b1;
            OpJe:    jump_taken = flags_q[1];
            OpJa:    jump_taken = flags_q[2];
            OpJb:    jump_taken = flags_q[0];
            OpJae:   jump_taken = flags_q[2] | flags_q[1];
            OpJbe:   jump_taken = flags_q[0] | flags_q[1];
            default: jump_taken = 1'b0;
        endcase
    end

    // State, IR, flags and start-edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ir_q    <= '0;
            flags_q <= 3'b000;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            start_q <= start;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        unique case (state_q)
            StIdle:   if (start_rise) state_d = StRst;
            StRst: begin
                flags_d = 3'b000;
                state_d = StFetch;
            end
            StFetch: begin
                ir_d    = instr;
                state_d = StDecode;
            end
            StDecode: state_d = (op == OpIll) ? StHalt : StExec;
            StExec: begin
                if (is_alu)      state_d = StWb;
                else if (is_mem) state_d = StMem;
                else             state_d = StFetch;
                if (op == OpCmp) flags_d = cmp_result;
            end
            StMem:    state_d = (op == OpLd) ? StWb : StFetch;
            StWb:     state_d = StFetch;
            StHalt:   if (start_rise) state_d = StRst;
            default:  state_d = StIdle;
        endcase
    end

    // Output decode from state and IR.
    always_comb begin
        dp_reset     = 1'b0;
        pc_inc       = 1'b0;
        pc_wrt       = 1'b0;
        pc_target    = '0;
        r1_addr      = '0;
        r2_addr      = '0;
        w_addr       = '0;
        regw_enable  = 1'b0;
        alu_select   = 4'b0000;
        alu_b_imm    = 1'b0;
        imm_ext      = '0;
        wb_sel       = 1'b0;
        ram_addr     = '0;
        ram_w_enable = 1'b0;
        busy         = (state_q != StIdle) && (state_q != StHalt);
        halted       = (state_q == StHalt);

        // Operand fields stay valid from DECODE through WB so the datapath sees stable inputs.
        if ((state_q == StDecode) || (state_q == StExec) || (state_q == StMem) ||
            (state_q == StWb)) begin
            if (is_mem || (op == OpCmp)) begin
                r1_addr = rd;
                r2_addr = rs1;
            end else begin
                r1_addr = rs1;
                r2_addr = rs2;
            end
            imm_ext   = {{(DATA_W-6){ir_q[5]}}, ir_q[5:0]};
            pc_target = ir_q[ADDR_W-1:0];
        end

        // ALU controls are driven in EXEC and held through WB.
        if (is_alu && ((state_q == StExec) || (state_q == StWb))) begin
            case (op)
                OpAdd, OpAddi: alu_select = 4'b0001;
                OpAnd, OpAndi: alu_select = 4'b0010;
                OpNand:        alu_select = 4'b0100;
                OpNor:         alu_select = 4'b1000;
                default:       alu_select = 4'b0000;
            endcase
            alu_b_imm = (op == OpAddi) || (op == OpAndi);
        end

        unique case (state_q)
            StRst: dp_reset = 1'b1;
            StExec: begin
                if (op == OpCmp) begin
                    pc_inc = 1'b1;
                end else if (is_jump) begin
                    pc_wrt = jump_taken;
                    pc_inc = !jump_taken;
                end
            end
            StMem: begin
                ram_addr = ir_q[ADDR_W-1:0];
                if (op == OpSt) begin
                    ram_w_enable = 1'b1;
                    pc_inc       = 1'b1;
                end
            end
            StWb: begin
                regw_enable = 1'b1;
                w_addr      = rd;
                wb_sel      = (op == OpLd);
                pc_inc      = 1'b1;
                // Keep the RAM address up while load data is written back.
                if (op == OpLd) ram_addr = ir_q[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

endmodule
